serial_in_parallel_out_rx: RTL and testbench
============================================

Name: serial_in_parallel_out_rx

Overview:
Receive-side deserializer for the team's shift-register serial link. It takes one bit per qualified clock and assembles WIDTH-bit words, MSB first by default, matching the transmitter, which shifts out bit [WIDTH-1] first. Each completed word is presented on a valid/ready parallel output with a one-word holding register. It also provides frame realignment and a sticky overrun flag. It sits between the serial wire (after any synchronizer) and the parallel consumer logic.

Parameters:
WIDTH, 4, word width in bits (>=2)
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0]

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
din  input  1  serial data bit
din_valid  input  1  din is sampled on this edge when high
frame_start  input  1  realign: discard partial word; if din_valid is also high, din is bit 0 of a new word
dout  output  WIDTH  assembled word (holding register)
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready
overrun  output  1  sticky: a completed word was dropped
clr_overrun  input  1  clears overrun (synchronous)
bit_cnt  output  clog2(WIDTH)  bits received in the current partial word

Behaviour:
- Reset (synchronous, priority over all other inputs) clears: shift register, bit_cnt, dout (all 0), dout_valid (0), overrun (0).
- Shift register, per edge with din_valid=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], din}.
  - MSB_FIRST=0: sr <= {din, sr[WIDTH-1:1]}.
  - bit_cnt increments.
  - With din_valid=0, sr and bit_cnt hold.
- Word complete: an edge where din_valid=1 and bit_cnt==WIDTH-1.
  - On that edge the assembled word (sr combined with the current din) is offered to the holding register.
  - bit_cnt wraps to 0.
- frame_start=1, din_valid=0: bit_cnt <= 0 and the partial word is discarded. No output change.
- frame_start=1, din_valid=1: din becomes bit 0 of a fresh word and bit_cnt <= 1. The old partial word is discarded; this never completes a word unless WIDTH==1, which is illegal.
- Holding register load: on a word-complete edge, the word loads into dout if dout_valid=0 or (dout_valid & dout_ready) on that edge. dout_valid <= 1.
- Latency: dout and dout_valid are visible the cycle after the edge that samples the last bit.
- Drain: dout_valid & dout_ready with no simultaneous load gives dout_valid <= 0. dout keeps its last value; it is not cleared.
- Stability: while dout_valid & !dout_ready, dout must not change.
- Simultaneous complete + drain: the new word loads, dout_valid stays 1, no overrun.
- Overrun: on word complete with dout_valid=1 and dout_ready=0:
  - The new word is dropped and the held dout is preserved.
  - overrun <= 1, and it stays 1 until reset or clr_overrun.
  - If clr_overrun and a new overrun event occur on the same edge, the set wins (overrun=1).
- Reset mid-word or with a word pending: everything is cleared as above, and the partial word and pending word are lost.

Test Plan:
1. WIDTH=4, MSB_FIRST=1; reset for 1 cycle; din 1,0,0,1 on 4 consecutive din_valid cycles; dout_ready=1 -> dout=4'b1001, dout_valid high for exactly 1 cycle, starting the cycle after the 4th bit; bit_cnt sequence 0,1,2,3,0.
2. Back-to-back words 1010 then 1011 with continuous din_valid, dout_ready=1 -> two dout_valid pulses 4 cycles apart with dout=1010 then 1011; overrun=0.
3. dout_ready=0; send 1110, then 1111 -> dout=1110 held, overrun=1 after the 2nd word completes, 1111 dropped. Then dout_ready=1 for 1 cycle -> dout_valid=0, dout stays 1110. Then clr_overrun=1 -> overrun=0.
4. Gapped input: din_valid pattern 1,0,1,0,1,1 with bits 0,x,0,x,1,1 -> dout=4'b0011; bit_cnt holds during gaps.
5. Send bits 1,1; then frame_start=1 with din_valid=1, din=0; then bits 1,0,1 -> dout=4'b0101; no word is emitted for the discarded 11.
6. Send 2 bits, then assert reset for 1 cycle; separately, reset while dout_valid=1 and overrun=1 -> all outputs 0, bit_cnt=0; next 4 bits 1001 produce dout=1001 normally. Repeat scenario 1 with MSB_FIRST=0 -> dout=4'b1001 bit-reversed (4'b1001).

Source files
------------

// File: rtl/serial_in_parallel_out_rx_if.sv
// -----------------------------------------------------------------------------
// serial_in_parallel_out_rx_if
//
// Bundles the serial input side and the parallel valid/ready output side of
// the serial_in_parallel_out_rx deserializer. clk and reset stay outside the
// interface and are plain ports on the receiver.
//
// Signals:
//   din          serial data bit
//   din_valid    din is sampled on this edge when high
//   frame_start  realign to a word boundary (discard the partial word)
//   dout         assembled word (holding register)
//   dout_valid   dout holds an unconsumed word
//   dout_ready   consumer accepts dout when dout_valid & dout_ready
//   overrun      sticky: a completed word was dropped
//   clr_overrun  clears overrun
//   bit_cnt      bits received in the current partial word
//
// Modports:
//   master  the environment: drives the serial bits, consumes the words
//   slave   the receiver itself
// -----------------------------------------------------------------------------
interface serial_in_parallel_out_rx_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             din;
  logic             din_valid;
  logic             frame_start;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic             clr_overrun;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output din,
    output din_valid,
    output frame_start,
    output dout_ready,
    output clr_overrun,
    input  dout,
    input  dout_valid,
    input  overrun,
    input  bit_cnt
  );

  modport slave (
    input  din,
    input  din_valid,
    input  frame_start,
    input  dout_ready,
    input  clr_overrun,
    output dout,
    output dout_valid,
    output overrun,
    output bit_cnt
  );

endinterface

// File: rtl/serial_in_parallel_out_rx.sv
// -----------------------------------------------------------------------------
// serial_in_parallel_out_rx
//
// Receive-side deserializer for the shift-register serial link. One bit is
// taken per clock on which din_valid is high; every WIDTH bits form a word
// that is offered to a one-word holding register with a valid/ready output.
//
// Bit order:
//   MSB_FIRST = 1  first received bit lands in dout[WIDTH-1] (matches the
//                  transmitter, which shifts out bit [WIDTH-1] first)
//   MSB_FIRST = 0  first received bit lands in dout[0]
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears all state, wins over every input
//   bus    serial_in_parallel_out_rx_if.slave (see the interface header)
//
// Behaviour summary:
//   - frame_start discards the partial word. Together with din_valid, din
//     becomes bit 0 of a fresh word (bit_cnt -> 1); alone, bit_cnt -> 0.
//   - A completed word loads dout when the holding register is empty or is
//     being drained on the same edge; dout/dout_valid appear the next cycle.
//   - A completed word arriving while dout is held and not accepted is
//     dropped and sets the sticky overrun flag. A set on the same edge as
//     clr_overrun wins.
//   - Draining clears dout_valid only; dout keeps its last value.
// -----------------------------------------------------------------------------
module serial_in_parallel_out_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  serial_in_parallel_out_rx_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // The partial word only ever needs WIDTH-1 stored bits: the final bit of a
  // word comes straight from din on the completing edge.
  localparam int SR_W = WIDTH - 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SR_W-1:0]  sr_q,         sr_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] dout_q,       dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q,    overrun_d;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [SR_W-1:0]  sr_base;   // partial word the incoming bit is added to
  logic [WIDTH-1:0] word;      // partial word combined with the current din
  logic             word_done; // this edge samples the last bit of a word
  logic             drain;     // consumer takes the held word this edge
  logic             load;      // completed word enters the holding register
  logic             overrun_evt;

  // A realignment with a valid bit starts from an empty partial word, so the
  // discarded bits can never leak into the next word.
  assign sr_base = bus.frame_start ? '0 : sr_q;

  generate
    if (MSB_FIRST) begin : g_msb_first
      // Older bits move toward the MSB; din enters at bit 0.
      assign word = {sr_base, bus.din};
    end else begin : g_lsb_first
      // Older bits move toward the LSB; din enters at the MSB.
      assign word = {bus.din, sr_base};
    end
  endgenerate

  // frame_start with din_valid always starts a new word, so it can never
  // complete one (WIDTH >= 2).
  assign word_done   = bus.din_valid && !bus.frame_start && (cnt_q == LAST_BIT);
  assign drain       = dout_valid_q && bus.dout_ready;
  assign load        = word_done && (!dout_valid_q || bus.dout_ready);
  assign overrun_evt = word_done && dout_valid_q && !bus.dout_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned here gets its hold value first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;

    // Serial side: shift register and bit counter.
    if (bus.din_valid) begin
      if (MSB_FIRST) begin
        sr_d = word[SR_W-1:0];
      end else begin
        sr_d = word[WIDTH-1:1];
      end

      if (bus.frame_start) begin
        cnt_d = CNT_W'(1);
      end else if (word_done) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.frame_start) begin
      sr_d  = '0;
      cnt_d = '0;
    end

    // Parallel side: one-word holding register.
    if (load) begin
      dout_d       = word;
      dout_valid_d = 1'b1;
    end else if (drain) begin
      dout_valid_d = 1'b0;
    end

    // Sticky overrun; a new event beats a simultaneous clear.
    if (overrun_evt) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.bit_cnt    = cnt_q;

endmodule

// File: tb/tb_serial_in_parallel_out_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_in_parallel_out_rx
//
// Directed bench for serial_in_parallel_out_rx. Two receivers (MSB-first and
// LSB-first, WIDTH=4) see identical stimulus; inputs change 1 ns after each
// rising edge and outputs are checked at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_serial_in_parallel_out_rx;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checks   = 0;
  int failures = 0;

  serial_in_parallel_out_rx_if #(.WIDTH(4)) sif_m ();
  serial_in_parallel_out_rx_if #(.WIDTH(4)) sif_l ();

  serial_in_parallel_out_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (sif_m)
  );

  serial_in_parallel_out_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (sif_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs to both receivers, clock once, settle 1 ns.
  task automatic step(input logic dv, input logic d, input logic fs,
                      input logic rdy, input logic clr);
    sif_m.din_valid   = dv;  sif_l.din_valid   = dv;
    sif_m.din         = d;   sif_l.din         = d;
    sif_m.frame_start = fs;  sif_l.frame_start = fs;
    sif_m.dout_ready  = rdy; sif_l.dout_ready  = rdy;
    sif_m.clr_overrun = clr; sif_l.clr_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  // Send w[3] first, then w[2], w[1], w[0], all with the same dout_ready.
  task automatic send_word(input logic [3:0] w, input logic rdy);
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, w[i], 1'b0, rdy, 1'b0);
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check("rst_dout",       sif_m.dout,       4'h0);
    check("rst_dout_valid", sif_m.dout_valid, 1'b0);
    check("rst_overrun",    sif_m.overrun,    1'b0);
    check("rst_bit_cnt",    sif_m.bit_cnt,    2'd0);

    // ---------------- 1: single word 1001 ----------------
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s1_cnt1", sif_m.bit_cnt, 2'd1);
    check("s1_dv_b1", sif_m.dout_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s1_cnt2", sif_m.bit_cnt, 2'd2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s1_cnt3", sif_m.bit_cnt, 2'd3);
    check("s1_dv_b3", sif_m.dout_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s1_cnt0", sif_m.bit_cnt, 2'd0);
    check("s1_dv",   sif_m.dout_valid, 1'b1);
    check("s1_dout", sif_m.dout, 4'b1001);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s1_dv_drop",  sif_m.dout_valid, 1'b0);
    check("s1_dout_keep", sif_m.dout, 4'b1001);

    // ---------------- 2: back-to-back 1010, 1011 ----------------
    send_word(4'b1010, 1'b1);
    check("s2_dv_a",   sif_m.dout_valid, 1'b1);
    check("s2_dout_a", sif_m.dout, 4'b1010);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s2_dv_gap", sif_m.dout_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s2_dv_gap3", sif_m.dout_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s2_dv_b",   sif_m.dout_valid, 1'b1);
    check("s2_dout_b", sif_m.dout, 4'b1011);
    check("s2_overrun", sif_m.overrun, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s2_drain", sif_m.dout_valid, 1'b0);

    // ---------------- 3: overrun, hold, clear ----------------
    send_word(4'b1110, 1'b0);
    check("s3_dv",   sif_m.dout_valid, 1'b1);
    check("s3_dout", sif_m.dout, 4'b1110);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("s3_no_ovr_yet", sif_m.overrun, 1'b0);
    check("s3_hold_mid", sif_m.dout, 4'b1110);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("s3_overrun",  sif_m.overrun, 1'b1);
    check("s3_dout_keep", sif_m.dout, 4'b1110);
    check("s3_dv_keep",  sif_m.dout_valid, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s3_drain_dv",   sif_m.dout_valid, 1'b0);
    check("s3_drain_dout", sif_m.dout, 4'b1110);
    check("s3_ovr_sticky", sif_m.overrun, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s3_clr", sif_m.overrun, 1'b0);

    // set and clear on the same edge: set wins
    send_word(4'b0001, 1'b0);
    check("s3b_dout", sif_m.dout, 4'b0001);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s3b_set_wins", sif_m.overrun, 1'b1);
    check("s3b_dout_keep", sif_m.dout, 4'b0001);

    // complete and drain on the same edge: new word loads, valid stays high
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s3c_dout", sif_m.dout, 4'b1100);
    check("s3c_dv",   sif_m.dout_valid, 1'b1);
    check("s3c_ovr",  sif_m.overrun, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("s3c_drain", sif_m.dout_valid, 1'b0);
    check("s3c_clr",   sif_m.overrun, 1'b0);

    // ---------------- 4: gapped input -> 0011 ----------------
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s4_cnt_a", sif_m.bit_cnt, 2'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s4_gap1", sif_m.bit_cnt, 2'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s4_cnt_b", sif_m.bit_cnt, 2'd2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s4_gap2", sif_m.bit_cnt, 2'd2);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s4_cnt_c", sif_m.bit_cnt, 2'd3);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s4_dout", sif_m.dout, 4'b0011);
    check("s4_dv",   sif_m.dout_valid, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s4_drain", sif_m.dout_valid, 1'b0);

    // ---------------- 5: realignment ----------------
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s5_cnt_pre", sif_m.bit_cnt, 2'd2);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("s5_cnt_fs", sif_m.bit_cnt, 2'd1);
    check("s5_dv_fs",  sif_m.dout_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s5_dv_pre", sif_m.dout_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s5_dout", sif_m.dout, 4'b0101);
    check("s5_dv",   sif_m.dout_valid, 1'b1);
    // frame_start alone while a word is held: counter clears, output untouched
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("s5_cnt_b", sif_m.bit_cnt, 2'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("s5_fs_cnt",  sif_m.bit_cnt, 2'd0);
    check("s5_fs_dv",   sif_m.dout_valid, 1'b1);
    check("s5_fs_dout", sif_m.dout, 4'b0101);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // ---------------- 6: reset mid-word and with a word pending ----------------
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s6_cnt_pre", sif_m.bit_cnt, 2'd2);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    check("s6a_cnt",  sif_m.bit_cnt, 2'd0);
    check("s6a_dout", sif_m.dout, 4'h0);
    check("s6a_dv",   sif_m.dout_valid, 1'b0);

    send_word(4'b1001, 1'b0);
    send_word(4'b0000, 1'b0);
    check("s6b_ovr_pre", sif_m.overrun, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check("s6b_dout",   sif_m.dout, 4'h0);
    check("s6b_dv",     sif_m.dout_valid, 1'b0);
    check("s6b_ovr",    sif_m.overrun, 1'b0);
    check("s6b_cnt",    sif_m.bit_cnt, 2'd0);
    check("s6b_l_dout", sif_l.dout, 4'h0);
    check("s6b_l_dv",   sif_l.dout_valid, 1'b0);
    check("s6b_l_ovr",  sif_l.overrun, 1'b0);

    // ---------------- after reset, both bit orders ----------------
    send_word(4'b1001, 1'b1);
    check("s6c_dout",   sif_m.dout, 4'b1001);
    check("s6c_dv",     sif_m.dout_valid, 1'b1);
    check("lsb_dout_a", sif_l.dout, 4'b1001);
    check("lsb_dv_a",   sif_l.dout_valid, 1'b1);
    send_word(4'b1100, 1'b1);
    check("msb_dout_b", sif_m.dout, 4'b1100);
    check("lsb_dout_b", sif_l.dout, 4'b0011);
    check("lsb_cnt_b",  sif_l.bit_cnt, 2'd0);
    check("lsb_ovr_b",  sif_l.overrun, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
